// File: rtl/mux_n_rr.sv
// N-channel registered multiplexer with fixed-select and round-robin arbitration.
// One word is captured per edge into an output register with valid/ready backpressure.
module mux_n_rr #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                        In_Clk,
    input  logic                        In_Rst_n,
    input  logic [CHANNELS*WIDTH-1:0]   In_Data,
    input  logic [CHANNELS-1:0]         In_Valid,
    input  logic [SEL_W-1:0]            In_Sel,
    input  logic                        In_Mode,
    input  logic                        In_Ready,
    output logic [WIDTH-1:0]            Out_Y,
    output logic                        Out_Valid,
    output logic [SEL_W-1:0]            Out_Ch,
    output logic [CHANNELS-1:0]         Out_Ack,
    output logic [15:0]                 Out_Count
);

    // Handshake: a word moves downstream on an edge where Out_Valid && In_Ready;
    // channel c is consumed on an edge where Out_Ack[c] is high (In_Valid[c] must hold until then).

    logic [SEL_W-1:0] rr_ptr;
    logic             fix_hit;
    logic             rr_hit;
    logic [SEL_W-1:0] rr_idx;
    logic             grant_vld;
    logic [SEL_W-1:0] grant_idx;
    logic [WIDTH-1:0] sel_data;
    logic             reg_free;
    logic             capture;
    logic [SEL_W-1:0] next_ptr;
    int               probe;

    // Fixed mode: an out-of-range In_Sel matches no channel, so it never grants.
    always_comb begin
        fix_hit = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (In_Sel == SEL_W'(c) && In_Valid[c]) fix_hit = 1'b1;
        end
    end

    // Round-robin: probe rr_ptr, rr_ptr+1, ... wrapping at CHANNELS (not at 2**SEL_W).
    always_comb begin
        rr_hit = 1'b0;
        rr_idx = '0;
        probe  = 0;
        for (int k = 0; k < CHANNELS; k++) begin
            probe = int'(rr_ptr) + k;
            if (probe >= CHANNELS) probe = probe - CHANNELS;
            for (int c = 0; c < CHANNELS; c++) begin
                if (!rr_hit && c == probe && In_Valid[c]) begin
                    rr_hit = 1'b1;
                    rr_idx = SEL_W'(c);
                end
            end
        end
    end

    always_comb begin
        grant_vld = In_Mode ? rr_hit : fix_hit;
        grant_idx = In_Mode ? rr_idx : In_Sel;
        reg_free  = !Out_Valid || In_Ready;
        capture   = In_Rst_n && reg_free && grant_vld;
        sel_data  = '0;
        Out_Ack   = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (grant_idx == SEL_W'(c)) begin
                sel_data   = In_Data[c*WIDTH +: WIDTH];
                Out_Ack[c] = capture;
            end
        end
        if (int'(grant_idx) >= CHANNELS - 1) next_ptr = '0;
        else                                 next_ptr = grant_idx + SEL_W'(1);
    end

    always_ff @(posedge In_Clk or negedge In_Rst_n) begin
        if (!In_Rst_n) begin
            Out_Y     <= '0;
            Out_Valid <= 1'b0;
            Out_Ch    <= '0;
            Out_Count <= '0;
            rr_ptr    <= '0;
        end else if (capture) begin
            Out_Y     <= sel_data;
            Out_Valid <= 1'b1;
            Out_Ch    <= grant_idx;
            if (Out_Count != 16'hFFFF) Out_Count <= Out_Count + 16'd1;
            if (In_Mode) rr_ptr <= next_ptr;
        end else if (Out_Valid && In_Ready) begin
            Out_Valid <= 1'b0;
        end
    end

endmodule

// File: doc/mux_n_rr.md
MUX_N_RR -- requirements
Module: mux_n_rr

Interface
REQ-001 Parameter WIDTH, default 8, data bits per channel (>=1).
REQ-002 Parameter CHANNELS, default 4, input channel count (2..16, non-power-of-two allowed).
REQ-003 Parameter SEL_W, default $clog2(CHANNELS), select/channel-index width.
REQ-004 Clocking SHALL be one clock, In_Clk, rising edge; reset SHALL be In_Rst_n, asynchronous, active-low.
REQ-005 In_Clk  input  1  clock.
REQ-006 In_Rst_n  input  1  asynchronous active-low reset.
REQ-007 In_Data  input  CHANNELS*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH].
REQ-008 In_Valid  input  CHANNELS  per-channel request; data held stable until acked.
REQ-009 In_Sel  input  SEL_W  channel index used in fixed mode.
REQ-010 In_Mode  input  1  0 = fixed select, 1 = round-robin.
REQ-011 In_Ready  input  1  downstream accepts Out_Y this cycle.
REQ-012 Out_Y  output  WIDTH  registered selected data.
REQ-013 Out_Valid  output  1  Out_Y holds an unconsumed word.
REQ-014 Out_Ch  output  SEL_W  index of channel that supplied Out_Y.
REQ-015 Out_Ack  output  CHANNELS  one-hot combinational grant; bit c high = channel c captured at this edge.
REQ-016 Out_Count  output  16  saturating count of completed captures.

Function
REQ-017 Output register SHALL be free when Out_Valid=0 or (Out_Valid=1 and In_Ready=1); capture SHALL occur only when free and a grant exists.
REQ-018 Fixed mode: grant = In_Sel iff In_Sel < CHANNELS and In_Valid[In_Sel]=1; otherwise no grant.
REQ-019 Round-robin mode: grant = first c with In_Valid[c]=1 searching rr_ptr, rr_ptr+1, ... wrapping CHANNELS-1 -> 0.
REQ-020 On each round-robin capture rr_ptr SHALL become (grant+1) mod CHANNELS; fixed-mode captures SHALL leave rr_ptr unchanged.
REQ-021 Out_Ack SHALL be zero whenever no capture occurs; at most one bit high per cycle.
REQ-022 Capture latency SHALL be one cycle: data granted at edge N appears on Out_Y/Out_Ch with Out_Valid=1 after edge N.
REQ-023 Out_Valid=1 with In_Ready=0 SHALL hold Out_Y, Out_Ch, Out_Valid unchanged and Out_Ack=0 (backpressure).
REQ-024 Out_Valid=1, In_Ready=1 and a grant in the same cycle SHALL consume and reload in one edge (full throughput, no bubble).
REQ-025 Out_Valid=1, In_Ready=1 and no grant SHALL clear Out_Valid at the edge; Out_Y retains last value.
REQ-026 In_Mode and In_Sel SHALL be sampled each cycle; a mode change takes effect on the next grant decision without flushing Out_Y.
REQ-027 Out_Count SHALL increment by 1 per capture and saturate at 16'hFFFF.
REQ-028 Out_Ack SHALL be gated by In_Rst_n=1 (no grant while reset asserted).

Reset
REQ-029 While In_Rst_n=0: Out_Y=0, Out_Valid=0, Out_Ch=0, Out_Ack=0, Out_Count=0, rr_ptr=0, immediately, independent of In_Clk.
REQ-030 Reset asserted mid-operation SHALL discard any pending Out_Y word without acknowledging further channels.
REQ-031 First capture SHALL be possible at the first rising edge after In_Rst_n deasserts.

Verification (WIDTH=8, CHANNELS=4)
REQ-032 Fixed: In_Mode=0, In_Sel=2, In_Valid=4'b0100, ch2=8'hA5, In_Ready=1 -> Out_Ack=4'b0100 that cycle; next cycle Out_Y=8'hA5, Out_Ch=2, Out_Valid=1, Out_Count=1.
REQ-033 Round-robin: In_Mode=1, In_Valid=4'b1111 held, In_Ready=1 -> Out_Ch sequence 0,1,2,3,0 on consecutive cycles, Out_Valid continuously 1.
REQ-034 Skip/wrap: In_Mode=1, rr_ptr=3 after grant of ch2, In_Valid=4'b0011 -> grant ch0, then ch1, then ch0.
REQ-035 Backpressure: Out_Valid=1, Out_Y=8'h3C, In_Ready=0 for 3 cycles with In_Valid=4'b1111 -> Out_Y stays 8'h3C, Out_Ack=0, Out_Count unchanged.
REQ-036 Reset mid-stream: assert In_Rst_n=0 between edges while Out_Valid=1 -> all outputs 0 immediately; after release, first capture starts from ch0.
REQ-037 Saturation: force 65536 captures -> Out_Count=16'hFFFF and stays there on further captures.
